seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 87 ++++++++
 tb/tb_seq_shifter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: captures an operand and shifts it one bit per clock.
// Define SEQ_SHIFTER_FAST_EN to take 4-bit strides while 4 or more bits remain.
module seq_shifter #(
  parameter int WIDTH = 32,
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SW-1:0]    shamt,
  input  logic             drxn,
  input  logic             type_i,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] work_q, out_q, shift_d;
  logic [SW-1:0]    cnt_q, step;
  logic             drxn_q, type_q, busy_q, done_q;

`ifdef SEQ_SHIFTER_FAST_EN
  assign step = (cnt_q >= SW'(4)) ? SW'(4) : SW'(1);
`else
  assign step = SW'(1);
`endif

  // Arithmetic right fill comes from the working MSB, which always holds the captured A[WIDTH-1].
  always_comb begin
    shift_d = work_q;
    if (drxn_q)      shift_d = work_q << step;
    else if (type_q) shift_d = $unsigned($signed(work_q) >>> step);
    else             shift_d = work_q >> step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      drxn_q  <= 1'b0;
      type_q  <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            work_q  <= A;
            cnt_q   <= shamt;
            drxn_q  <= drxn;
            type_q  <= type_i;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt_q == '0 || cnt_q == step) begin
            // shamt == 0 completes on the first edge with the operand untouched.
            out_q   <= (cnt_q == '0) ? work_q : shift_d;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            work_q <= shift_d;
            cnt_q  <= cnt_q - step;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: results, latency, back-to-back, ignored start, reset abort.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst, start, drxn, typ;
  logic [31:0] A, out;
  logic [4:0]  shamt;
  logic        busy, done;
  int          checks = 0;
  int          errors = 0;

  seq_shifter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .shamt(shamt),
    .drxn(drxn), .type_i(typ), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int sh);
    int l;
`ifdef SEQ_SHIFTER_FAST_EN
    l = sh / 4 + sh % 4;
`else
    l = sh;
`endif
    return (l < 1) ? 1 : l;
  endfunction

  // Launch one op, scramble inputs after capture, optionally hold start high into SHIFT.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                        input logic d, input logic t, input logic [31:0] exp, input logic mid);
    int n;
    @(negedge clk);
    A = a; shamt = sh; drxn = d; typ = t; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_cap"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = mid; A = ~a; shamt = ~sh; drxn = ~d; typ = ~t;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) start = 1'b0;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat(int'(sh))));
    chk({tag, "_out"}, out, exp);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, out, exp);
  endtask

  initial begin
    int n, pulses;
    rst = 1'b1; start = 1'b1; A = 32'hDEADBEEF; shamt = 5'd3; drxn = 1'b0; typ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0; start = 1'b0;

    run_op("l_log3",  32'h80000000, 5'd3,  1'b1, 1'b0, 32'h00000000, 1'b0);
    run_op("r_log3",  32'h80000000, 5'd3,  1'b0, 1'b0, 32'h10000000, 1'b0);
    run_op("r_ari3",  32'h80000000, 5'd3,  1'b0, 1'b1, 32'hF0000000, 1'b0);
    run_op("l_ari3",  32'h80000000, 5'd3,  1'b1, 1'b1, 32'h00000000, 1'b0);
    run_op("r_ari31", 32'h80000000, 5'd31, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_op("l_log31", 32'h00000001, 5'd31, 1'b1, 1'b0, 32'h80000000, 1'b0);
    run_op("l_log4",  32'h12345678, 5'd4,  1'b1, 1'b0, 32'h23456780, 1'b0);
    run_op("r_log5",  32'h12345678, 5'd5,  1'b0, 1'b0, 32'h0091A2B3, 1'b0);
    run_op("l_ari9",  32'hF0F0F0F0, 5'd9,  1'b1, 1'b1, 32'hE1E1E000, 1'b0);
    run_op("r_ari_pos", 32'h7F000000, 5'd6, 1'b0, 1'b1, 32'h01FC0000, 1'b0);
    run_op("mid_start", 32'h80000000, 5'd8, 1'b0, 1'b1, 32'hFF800000, 1'b1);

    // shamt = 0 then a second start in the DONE cycle
    @(negedge clk);
    A = 32'h12345678; shamt = 5'd0; drxn = 1'b0; typ = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; A = 32'h0;
    @(posedge clk); #1;
    chk("z_done", 32'(done), 32'd1);
    chk("z_out", out, 32'h12345678);
    @(negedge clk);
    A = 32'h00000001; shamt = 5'd4; drxn = 1'b1; typ = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    start = 1'b0; A = 32'hFFFFFFFF;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_lat", 32'(n), 32'(exp_lat(4)));
    chk("b2b_out", out, 32'h00000010);

    // reset in the middle of a long operation
    @(negedge clk);
    A = 32'h0000FFFF; shamt = 5'd20; drxn = 1'b1; typ = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out", out, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op("post_rst", 32'h0000FFFF, 5'd20, 1'b1, 1'b0, 32'hFFF00000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
